// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_ctrl_pkg : shared types and helpers for the nibble adder   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder4_cin.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder4_cin : 4-bit ripple adder with carry-in                    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module adder4_cin (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nibble_serial_adder_ctrl : WIDTH-bit add over one 4-bit adder,   |
// | LS nibble first, carry held between steps. Rev 1.0               |
// +------------------------------------------------------------------+
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      NIB      = nib_count(WIDTH);
  localparam int unsigned      IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] w_nib_a, w_nib_b, w_nib_sum;
  logic                w_nib_cout;

  assign w_nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign w_nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  adder4_cin u_adder4 (
    .A    (w_nib_a),
    .B    (w_nib_b),
    .Cin  (carry_q),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[idx_q*NIBBLE_W +: NIBBLE_W] = w_nib_sum;
        carry_d = w_nib_cout;
        idx_d   = idx_q + IDX_W'(1);
        // Publish on the last step so the final nibble lands in sum directly.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_d;
          cout_d  = w_nib_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_nibble_serial_adder_ctrl : scoreboard bench for the adder     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b, sum;
  logic             ready, busy, done, cout;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] val;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  exp_t           e;
  int             cyc       = 0;
  int             next_free = 0;
  int             acc_cyc   = -1000;
  bit             armed     = 1'b0;
  logic [WIDTH:0] held      = '0;
  int             n_tests   = 0;
  int             n_fail    = 0;
  bit             e_busy, e_done, e_ready;

  // Reference model: an accepted add of a+b completes NIB+1 cycles later.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      next_free = cyc + 1;
      acc_cyc   = -1000;
      held      = '0;
      armed     = 1'b1;
    end else if (start && cyc >= next_free) begin
      e.val = {1'b0, a} + {1'b0, b};
      e.cyc = cyc + NIB + 1;
      sb.push_back(e);
      next_free = cyc + NIB + 2;
      acc_cyc   = cyc;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      e_busy  = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + NIB);
      e_done  = (sb.size() > 0) && (sb[0].cyc == cyc);
      e_ready = (cyc >= next_free);
      n_tests++;
      if ({ready, busy, done} !== {e_ready, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d ready/busy/done got %b%b%b required %b%b%b",
                 cyc, ready, busy, done, e_ready, e_busy, e_done);
      end
      if (e_done) begin
        e    = sb.pop_front();
        held = e.val;
      end
      n_tests++;
      if ({cout, sum} !== held) begin
        n_fail++;
        $display("FAIL result cyc=%0d cout/sum got %b/%h required %b/%h",
                 cyc, cout, sum, held[WIDTH], held[WIDTH-1:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted start followed by junk inputs while the add runs.
  task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    step();
    for (int i = 0; i < NIB + 1; i++) begin
      start = 1'($urandom);
      a     = (i == 1) ? '1 : WIDTH'($urandom);
      b     = (i == 1) ? '1 : WIDTH'($urandom);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) step();
    rst = 1'b0;

    do_add(16'h0001, 16'h000F);
    do_add(16'hFFFF, 16'h0001);
    do_add(16'hFFFF, 16'hFFFF);
    do_add(16'h1234, 16'h4321);

    // Reset lands in the second RUN cycle; that add must never complete.
    start = 1'b1;
    a     = 16'h5A5A;
    b     = 16'hA5A5;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (NIB + 2) step();

    start = 1'b1;
    a     = 16'h00F0;
    b     = 16'h0F10;
    repeat (4 * (NIB + 2)) step();
    start = 1'b0;
    repeat (NIB + 2) step();

    repeat (600) begin
      start = 1'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      rst   = ($urandom_range(0, 49) == 0);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (NIB + 3) step();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending results got %0d required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
